// File: rtl/aor_pkg.sv
// Shared constants, FSM state encoding and result popcount for the AOR key-sweep sequencer.
package aor_pkg;

  localparam int unsigned DW  = 16;
  localparam int unsigned KW  = 32;
  localparam int unsigned AW  = 14;
  localparam int unsigned PCW = $clog2(DW + 2);

  typedef enum logic [2:0] {
    StIdle,
    StFetchA,
    StFetchB,
    StSettle,
    StCompare,
    StReport,
    StDone
  } sweep_state_e;

  function automatic logic [PCW-1:0] popcount(input logic [DW:0] v);
    logic [PCW-1:0] c;
    c = '0;
    for (int i = 0; i <= int'(DW); i++) begin
      c = c + PCW'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/aor_key_table.sv
// Trial-key register file: synchronous write, asynchronous read, deliberately not reset.
module aor_key_table
  import aor_pkg::*;
#(
  parameter int unsigned NKEYS = 16,
  parameter int unsigned IW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [KW-1:0] wr_data_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [KW-1:0] rd_data_o
);

  logic [KW-1:0] mem_q [NKEYS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/aor_key_sweep_ctrl.sv
// Scores each trial key against the reference key by streaming operand pairs through an adder pair
// and accumulating the Hamming distance and mismatch count of their results.
module aor_key_sweep_ctrl
  import aor_pkg::*;
#(
  parameter int unsigned NPAIRS = 5000,
  parameter int unsigned NKEYS  = 16,
  parameter int unsigned SETTLE = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [KW-1:0] key_ref_i,
  input  logic [4:0]    key_cnt_i,
  input  logic          key_wr_i,
  input  logic [3:0]    key_wr_idx_i,
  input  logic [KW-1:0] key_wr_data_i,
  output logic          mem_rd_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [DW-1:0] mem_data_i,
  output logic [DW-1:0] add1_o,
  output logic [DW-1:0] add2_o,
  output logic [KW-1:0] key_ref_o,
  output logic [KW-1:0] key_trial_o,
  input  logic [DW:0]   res_ref_i,
  input  logic [DW:0]   res_trial_i,
  output logic          rpt_valid_o,
  input  logic          rpt_ready_i,
  output logic [3:0]    rpt_idx_o,
  output logic [31:0]   rpt_hd_o,
  output logic [AW-1:0] rpt_err_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SettleLast = SW'(SETTLE - 1);
  localparam logic [AW-2:0] PairLast   = (AW-1)'(NPAIRS - 1);

  sweep_state_e  state_q;
  logic          mem_rd_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] a_q, add1_q, add2_q;
  logic [KW-1:0] key_ref_q, key_trial_q;
  logic [4:0]    key_cnt_q;
  logic [3:0]    kidx_q;
  logic [AW-2:0] p_q;
  logic [SW-1:0] settle_q;
  logic [31:0]   hd_q;
  logic [AW-1:0] err_q;
  logic          rpt_valid_q, busy_q, done_q;

  logic [KW-1:0]  tbl_rd_data;
  logic [3:0]     tbl_rd_idx;
  logic [DW:0]    res_xor;
  logic [PCW-1:0] pc;
  logic [32:0]    hd_sum;
  logic [31:0]    hd_sat;
  logic [AW-2:0]  p_inc;
  logic           last_key;

  // Table is only read when loading a new trial key: index 0 at start, next index on accept.
  assign tbl_rd_idx = (state_q == StReport) ? kidx_q + 4'd1 : 4'd0;

  aor_key_table #(
    .NKEYS(NKEYS),
    .IW   (4)
  ) u_key_table (
    .clk_i    (clk),
    .we_i     (key_wr_i && !busy_q),
    .wr_idx_i (key_wr_idx_i),
    .wr_data_i(key_wr_data_i),
    .rd_idx_i (tbl_rd_idx),
    .rd_data_o(tbl_rd_data)
  );

  assign res_xor  = res_ref_i ^ res_trial_i;
  assign pc       = popcount(res_xor);
  assign hd_sum   = {1'b0, hd_q} + 33'(pc);
  assign hd_sat   = hd_sum[32] ? 32'hFFFF_FFFF : hd_sum[31:0];
  assign p_inc    = p_q + 1'b1;
  assign last_key = ({1'b0, kidx_q} + 5'd1) == key_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      a_q         <= '0;
      add1_q      <= '0;
      add2_q      <= '0;
      key_ref_q   <= '0;
      key_trial_q <= '0;
      key_cnt_q   <= '0;
      kidx_q      <= '0;
      p_q         <= '0;
      settle_q    <= '0;
      hd_q        <= '0;
      err_q       <= '0;
      rpt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mem_rd_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            key_cnt_q <= key_cnt_i;
            busy_q    <= 1'b1;
            kidx_q    <= '0;
            p_q       <= '0;
            hd_q      <= '0;
            err_q     <= '0;
            if (key_cnt_i == 5'd0) begin
              state_q <= StDone;
            end else begin
              key_ref_q   <= key_ref_i;
              key_trial_q <= tbl_rd_data;
              mem_rd_q    <= 1'b1;
              mem_addr_q  <= '0;
              state_q     <= StFetchA;
            end
          end
        end
        StFetchA: begin
          mem_rd_q   <= 1'b1;
          mem_addr_q <= {p_q, 1'b1};
          state_q    <= StFetchB;
        end
        StFetchB: begin
          a_q      <= mem_data_i;
          settle_q <= SettleLast;
          state_q  <= StSettle;
        end
        StSettle: begin
          // Operand B is on the RAM bus during the first settle cycle; both operands move together.
          if (settle_q == SettleLast) begin
            add1_q <= a_q;
            add2_q <= mem_data_i;
          end
          if (settle_q == '0) begin
            state_q <= StCompare;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        StCompare: begin
          hd_q  <= hd_sat;
          err_q <= err_q + AW'(res_xor != '0);
          if (p_q == PairLast) begin
            rpt_valid_q <= 1'b1;
            state_q     <= StReport;
          end else begin
            p_q        <= p_inc;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= {p_inc, 1'b0};
            state_q    <= StFetchA;
          end
        end
        StReport: begin
          if (rpt_ready_i) begin
            rpt_valid_q <= 1'b0;
            hd_q        <= '0;
            err_q       <= '0;
            kidx_q      <= kidx_q + 4'd1;
            if (last_key) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StDone;
            end else begin
              key_trial_q <= tbl_rd_data;
              p_q         <= '0;
              mem_rd_q    <= 1'b1;
              mem_addr_q  <= '0;
              state_q     <= StFetchA;
            end
          end
        end
        StDone: begin
          // An empty sweep arrives here still busy: spend one cycle raising done and dropping busy.
          if (busy_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            done_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_rd_o    = mem_rd_q;
  assign mem_addr_o  = mem_addr_q;
  assign add1_o      = add1_q;
  assign add2_o      = add2_q;
  assign key_ref_o   = key_ref_q;
  assign key_trial_o = key_trial_q;
  assign rpt_valid_o = rpt_valid_q;
  assign rpt_idx_o   = kidx_q;
  assign rpt_hd_o    = hd_q;
  assign rpt_err_o   = err_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_aor_key_sweep_ctrl.sv
// Directed bench for the key-sweep sequencer with a stub adder pair and a one-cycle-latency operand RAM.
module tb_aor_key_sweep_ctrl;
  import aor_pkg::*;

  localparam int NP = 4;
  localparam logic [31:0] RefKey = 32'h34A3_BDE0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [KW-1:0] key_ref_i = '0;
  logic [4:0]    key_cnt_i = '0;
  logic          key_wr_i = 1'b0;
  logic [3:0]    key_wr_idx_i = '0;
  logic [KW-1:0] key_wr_data_i = '0;
  logic          mem_rd_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_i;
  logic [DW-1:0] add1_o, add2_o;
  logic [KW-1:0] key_ref_o, key_trial_o;
  logic [DW:0]   res_ref_i, res_trial_i;
  logic          rpt_valid_o;
  logic          rpt_ready_i = 1'b1;
  logic [3:0]    rpt_idx_o;
  logic [31:0]   rpt_hd_o;
  logic [AW-1:0] rpt_err_o;
  logic          busy_o, done_o;

  int tests = 0;
  int fails = 0;

  aor_key_sweep_ctrl #(
    .NPAIRS(NP),
    .NKEYS (16),
    .SETTLE(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .key_ref_i    (key_ref_i),
    .key_cnt_i    (key_cnt_i),
    .key_wr_i     (key_wr_i),
    .key_wr_idx_i (key_wr_idx_i),
    .key_wr_data_i(key_wr_data_i),
    .mem_rd_o     (mem_rd_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_i   (mem_data_i),
    .add1_o       (add1_o),
    .add2_o       (add2_o),
    .key_ref_o    (key_ref_o),
    .key_trial_o  (key_trial_o),
    .res_ref_i    (res_ref_i),
    .res_trial_i  (res_trial_i),
    .rpt_valid_o  (rpt_valid_o),
    .rpt_ready_i  (rpt_ready_i),
    .rpt_idx_o    (rpt_idx_o),
    .rpt_hd_o     (rpt_hd_o),
    .rpt_err_o    (rpt_err_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  // Operand RAM and stub adder pair.
  logic [DW-1:0] ram [2*NP];
  logic [DW-1:0] ram_q = '0;
  logic [KW-1:0] key_diff;
  always @(posedge clk) if (mem_rd_o) ram_q <= ram[int'(mem_addr_o) % (2 * NP)];
  assign mem_data_i  = ram_q;
  assign key_diff    = key_trial_o ^ key_ref_o;
  assign res_ref_i   = {1'b0, add1_o} + {1'b0, add2_o};
  assign res_trial_i = res_ref_i ^ key_diff[DW:0];

  // Event counters, written only here; tasks take differences.
  int rd_cnt = 0, acc_cnt = 0, done_cnt = 0, busy_cnt = 0, valid_cnt = 0;
  always @(posedge clk) begin
    if (mem_rd_o) rd_cnt++;
    if (rpt_valid_o && rpt_ready_i) acc_cnt++;
    if (done_o) done_cnt++;
    if (busy_o) busy_cnt++;
    if (rpt_valid_o) valid_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_key(input logic [3:0] idx, input logic [31:0] data);
    key_wr_i = 1'b1; key_wr_idx_i = idx; key_wr_data_i = data;
    cyc(1);
    key_wr_i = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] rkey, input logic [4:0] cnt);
    start_i = 1'b1; key_ref_i = rkey; key_cnt_i = cnt;
    cyc(1);
    start_i = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rpt_valid_o) begin ok = 1'b1; break; end
      cyc(1);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_o) begin ok = 1'b1; break; end
      cyc(1);
    end
  endtask

  task automatic test_reset();
    logic [127:0] outs;
    outs = {mem_rd_o, mem_addr_o, add1_o, add2_o, rpt_valid_o, rpt_idx_o, rpt_err_o,
            busy_o, done_o};
    tests++;
    if (outs !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
    tests++;
    if ({key_ref_o, key_trial_o, rpt_hd_o} !== 96'd0) begin
      fails++; $display("FAIL reset_keys_hd: got %h want 0", {key_ref_o, key_trial_o, rpt_hd_o});
    end
  endtask

  task automatic test_match();
    bit ok; int rd0;
    wr_key(4'd0, RefKey);
    rd0 = rd_cnt;
    do_start(RefKey, 5'd1);
    wait_valid(ok);
    tests++;
    if (!ok || rpt_idx_o !== 4'd0 || rpt_hd_o !== 32'd0 || rpt_err_o !== '0) begin
      fails++;
      $display("FAIL match_record: valid %0b idx %0d hd %0d err %0d want idx 0 hd 0 err 0",
               ok, rpt_idx_o, rpt_hd_o, rpt_err_o);
    end
    wait_done(ok);
    tests++;
    if (!ok || busy_o !== 1'b0) begin
      fails++; $display("FAIL match_done: done seen %0b busy %0b want 1/0", ok, busy_o);
    end
    tests++;
    if (rd_cnt - rd0 != 2 * NP) begin
      fails++; $display("FAIL match_reads: got %0d want %0d", rd_cnt - rd0, 2 * NP);
    end
    cyc(2);
  endtask

  task automatic test_two_keys();
    bit ok;
    wr_key(4'd0, 32'h34A3_BDE1);
    wr_key(4'd1, 32'h34A3_BDE7);
    do_start(RefKey, 5'd2);
    wait_valid(ok);
    tests++;
    if (!ok || rpt_idx_o !== 4'd0 || rpt_hd_o !== 32'd4 || rpt_err_o !== 14'd4) begin
      fails++;
      $display("FAIL two_keys_rec0: valid %0b idx %0d hd %0d err %0d want 0/4/4",
               ok, rpt_idx_o, rpt_hd_o, rpt_err_o);
    end
    cyc(1);
    wait_valid(ok);
    tests++;
    if (!ok || rpt_idx_o !== 4'd1 || rpt_hd_o !== 32'd12 || rpt_err_o !== 14'd4) begin
      fails++;
      $display("FAIL two_keys_rec1: valid %0b idx %0d hd %0d err %0d want 1/12/4",
               ok, rpt_idx_o, rpt_hd_o, rpt_err_o);
    end
    wait_done(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL two_keys_done: got no done want pulse"); end
    cyc(2);
  endtask

  task automatic test_backpressure();
    bit ok; int rd0, acc0, bad;
    wr_key(4'd0, 32'h34A3_BDE7);
    rpt_ready_i = 1'b0;
    acc0 = acc_cnt;
    do_start(RefKey, 5'd1);
    wait_valid(ok);
    rd0 = rd_cnt;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (rpt_valid_o !== 1'b1 || rpt_idx_o !== 4'd0 || rpt_hd_o !== 32'd12 ||
          rpt_err_o !== 14'd4 || mem_rd_o !== 1'b0) bad++;
    end
    tests++;
    if (!ok || bad != 0) begin
      fails++; $display("FAIL bp_hold: seen %0b unstable cycles %0d want 0", ok, bad);
    end
    tests++;
    if (rd_cnt != rd0) begin
      fails++; $display("FAIL bp_no_reads: got %0d reads want 0", rd_cnt - rd0);
    end
    rpt_ready_i = 1'b1;
    cyc(1);
    tests++;
    if (rpt_valid_o !== 1'b0) begin
      fails++; $display("FAIL bp_valid_drop: got %0b want 0", rpt_valid_o);
    end
    wait_done(ok);
    cyc(3);
    tests++;
    if (!ok || acc_cnt - acc0 != 1) begin
      fails++; $display("FAIL bp_accepts: done %0b accepts %0d want 1", ok, acc_cnt - acc0);
    end
  endtask

  task automatic test_zero_keys();
    int rd0, bz0, dn0, vl0;
    rd0 = rd_cnt; bz0 = busy_cnt; dn0 = done_cnt; vl0 = valid_cnt;
    do_start(RefKey, 5'd0);
    cyc(6);
    tests++;
    if (busy_cnt - bz0 != 1 || done_cnt - dn0 != 1) begin
      fails++;
      $display("FAIL zero_busy_done: busy %0d done %0d want 1/1", busy_cnt - bz0, done_cnt - dn0);
    end
    tests++;
    if (rd_cnt != rd0 || valid_cnt != vl0) begin
      fails++;
      $display("FAIL zero_quiet: reads %0d valids %0d want 0/0", rd_cnt - rd0, valid_cnt - vl0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int acc0;
    logic [127:0] outs;
    wr_key(4'd0, 32'h34A3_BDE1);
    acc0 = acc_cnt;
    do_start(RefKey, 5'd1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mem_rd_o && mem_addr_o == 14'd5) begin ok = 1'b1; break; end
      cyc(1);
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL mid_find_pair2: got no read of addr 5 want one"); end
    cyc(1);
    rst = 1'b1;
    #1;
    outs = {mem_rd_o, mem_addr_o, add1_o, add2_o, rpt_valid_o, rpt_idx_o, rpt_err_o,
            busy_o, done_o, rpt_hd_o};
    tests++;
    if (outs !== '0 || {key_ref_o, key_trial_o} !== 64'd0) begin
      fails++; $display("FAIL mid_reset_outputs: got %h want 0", outs);
    end
    cyc(2);
    rst = 1'b0;
    cyc(1);
    do_start(RefKey, 5'd1);
    tests++;
    if (mem_rd_o !== 1'b1 || mem_addr_o !== '0) begin
      fails++; $display("FAIL mid_restart_addr: rd %0b addr %0d want 1/0", mem_rd_o, mem_addr_o);
    end
    wait_valid(ok);
    tests++;
    if (!ok || rpt_hd_o !== 32'd4 || rpt_err_o !== 14'd4 || acc_cnt != acc0) begin
      fails++;
      $display("FAIL mid_restart_rec: valid %0b hd %0d err %0d prior accepts %0d want 4/4/0",
               ok, rpt_hd_o, rpt_err_o, acc_cnt - acc0);
    end
    wait_done(ok);
    cyc(2);
  endtask

  task automatic test_busy_ignore();
    bit ok; int bad;
    do_start(RefKey, 5'd1);
    cyc(3);
    key_wr_i = 1'b1; key_wr_idx_i = 4'd0; key_wr_data_i = 32'hFFFF_FFFF;
    start_i = 1'b1; key_cnt_i = 5'd3;
    cyc(1);
    key_wr_i = 1'b0; start_i = 1'b0;
    wait_valid(ok);
    tests++;
    if (!ok || rpt_hd_o !== 32'd4 || rpt_err_o !== 14'd4) begin
      fails++; $display("FAIL busy_rec: valid %0b hd %0d err %0d want 4/4", ok, rpt_hd_o, rpt_err_o);
    end
    wait_done(ok);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (busy_o !== 1'b0) bad++;
    end
    tests++;
    if (!ok || bad != 0) begin
      fails++; $display("FAIL busy_no_relaunch: done %0b busy cycles %0d want 0", ok, bad);
    end
    do_start(RefKey, 5'd1);
    wait_valid(ok);
    tests++;
    if (!ok || rpt_hd_o !== 32'd4) begin
      fails++; $display("FAIL busy_table_kept: valid %0b hd %0d want 4", ok, rpt_hd_o);
    end
    wait_done(ok);
    cyc(2);
  endtask

  initial begin
    for (int i = 0; i < 2 * NP; i++) ram[i] = DW'(16'h1357 * (i + 1));
    #1;
    cyc(2);
    test_reset();
    rst = 1'b0;
    cyc(1);
    test_match();
    test_two_keys();
    test_backpressure();
    test_zero_keys();
    test_reset_mid();
    test_busy_ignore();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
